// File: rtl/nreg_pkg.sv
// Purpose: shared constants and the delay-clamp helper for the nreg delay line family.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package nreg_pkg;

  localparam int NREG_MAX_DEPTH_LIMIT = 256;
  localparam int ERRCNT_W             = 16;

  // Map a requested delay onto the legal range 1..max_depth.
  // A request of 0 still yields one stage of delay.
  function automatic int unsigned clamp_delay(input int unsigned sel,
                                              input int unsigned max_depth);
    if (sel == 0) begin
      return 1;
    end else if (sel > max_depth) begin
      return max_depth;
    end else begin
      return sel;
    end
  endfunction

endpackage

// File: rtl/nreg_tap_mux.sv
// Purpose: select stage[d_act-1] from a packed stage array onto dout.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs continuously.
module nreg_tap_mux
  import nreg_pkg::*;
#(
  parameter int WIDTH     = 1,
  parameter int MAX_DEPTH = NREG_MAX_DEPTH_LIMIT,
  parameter int DSEL_W    = $clog2(MAX_DEPTH) + 1
) (
  input  logic [MAX_DEPTH-1:0][WIDTH-1:0] stages,
  input  logic [DSEL_W-1:0]               d_act,
  output logic [WIDTH-1:0]                dout
);

  // One-hot style compare avoids indexing with a wider-than-needed select;
  // d_act is always 1..MAX_DEPTH so exactly one arm matches.
  always_comb begin
    dout = '0;
    for (int k = 0; k < MAX_DEPTH; k++) begin
      if (d_act == DSEL_W'(k + 1)) begin
        dout = stages[k];
      end
    end
  end

endmodule

// File: rtl/nreg_delay_line.sv
// Purpose: WIDTH-bit shift-register delay line with runtime tap select, fill-based
//          out_valid, and an optional pattern self-test (macro NREG_SELFTEST_EN).
// Latency: d_act enabled edges from din to dout; no backpressure, en simply holds all state.
module nreg_delay_line
  import nreg_pkg::*;
#(
  parameter int  WIDTH     = 1,
  parameter int  MAX_DEPTH = 256,
  localparam int DSEL_W    = $clog2(MAX_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [WIDTH-1:0]  din,
  input  logic [DSEL_W-1:0] delay_sel,
  input  logic              load,
`ifdef NREG_SELFTEST_EN
  input  logic                selftest,
  output logic [ERRCNT_W-1:0] err_cnt,
`endif
  output logic [WIDTH-1:0]  dout,
  output logic              out_valid,
  output logic [7:0]        leds,
  output logic              clk_out
);

  logic [MAX_DEPTH-1:0][WIDTH-1:0] stage_bus;
  logic [WIDTH-1:0]                stage0_in;
  logic [DSEL_W-1:0]               d_act_d, d_act_q;
  logic [DSEL_W-1:0]               cnt_d, cnt_q;
  logic                            out_valid_d, out_valid_q;

  // Scope monitor copy of the clock under test.
  assign clk_out = clk;

`ifdef NREG_SELFTEST_EN
  logic [WIDTH-1:0]    pat_d, pat_q;
  logic [ERRCNT_W-1:0] err_d, err_q;
  logic                mismatch;

  assign stage0_in = selftest ? pat_q : din;

  // Free-running pattern and saturating mismatch counter; load restarts the count.
  always_comb begin
    pat_d    = en ? pat_q + WIDTH'(1) : pat_q;
    mismatch = en && out_valid_q && selftest && (dout != (pat_q - WIDTH'(d_act_q)));
    err_d    = err_q;
    if (load) begin
      err_d = '0;
    end else if (mismatch && (err_q != '1)) begin
      err_d = err_q + ERRCNT_W'(1);
    end
  end

  // Self-test state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q <= '0;
      err_q <= '0;
    end else begin
      pat_q <= pat_d;
      err_q <= err_d;
    end
  end

  assign err_cnt = err_q;
`else
  assign stage0_in = din;
`endif

  // Stage array: each stage loads its predecessor on an enabled edge.
  for (genvar k = 0; k < MAX_DEPTH; k++) begin : g_stage
    logic [WIDTH-1:0] stg_d, stg_q;
    logic [WIDTH-1:0] stg_prev;

    if (k == 0) begin : g_head
      assign stg_prev = stage0_in;
    end else begin : g_body
      assign stg_prev = stage_bus[k-1];
    end

    // Advance or hold this stage.
    always_comb begin
      stg_d = en ? stg_prev : stg_q;
    end

    // Stage register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stg_q <= '0;
      end else begin
        stg_q <= stg_d;
      end
    end

    assign stage_bus[k] = stg_q;
  end

  // Delay capture and fill tracking; load wins over en for the counter only.
  always_comb begin
    d_act_d = load ? DSEL_W'(clamp_delay(32'(delay_sel), MAX_DEPTH)) : d_act_q;
    cnt_d   = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (en && (cnt_q < d_act_q)) begin
      cnt_d = cnt_q + DSEL_W'(1);
    end
    // Registered flag tracks the post-edge counter against the post-edge delay.
    out_valid_d = (cnt_d == d_act_d);
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_act_q     <= DSEL_W'(MAX_DEPTH);
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      d_act_q     <= d_act_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;

  // LEDs show the low byte of the active delay (256 reads as 8'h00).
  if (DSEL_W >= 8) begin : g_leds_wide
    assign leds = d_act_q[7:0];
  end else begin : g_leds_narrow
    assign leds = {{(8 - DSEL_W){1'b0}}, d_act_q};
  end

  nreg_tap_mux #(
    .WIDTH     (WIDTH),
    .MAX_DEPTH (MAX_DEPTH),
    .DSEL_W    (DSEL_W)
  ) u_tap_mux (
    .stages (stage_bus),
    .d_act  (d_act_q),
    .dout   (dout)
  );

endmodule

// File: tb/tb_nreg_delay_line.sv
// Purpose: directed self-checking bench for nreg_delay_line (WIDTH=8, MAX_DEPTH=256).
// Latency: checks exact enabled-edge latency for several tap settings.
// Backpressure: exercises en gaps, load during fill and asynchronous reset.
module tb_nreg_delay_line;

  localparam int WIDTH     = 8;
  localparam int MAX_DEPTH = 256;
  localparam int DSEL_W    = 9;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic [WIDTH-1:0]  din;
  logic [DSEL_W-1:0] delay_sel;
  logic              load;
  logic [WIDTH-1:0]  dout;
  logic              out_valid;
  logic [7:0]        leds;
  logic              clk_out;
`ifdef NREG_SELFTEST_EN
  logic              selftest;
  logic [15:0]       err_cnt;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nreg_delay_line #(
    .WIDTH     (WIDTH),
    .MAX_DEPTH (MAX_DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .din       (din),
    .delay_sel (delay_sel),
    .load      (load),
`ifdef NREG_SELFTEST_EN
    .selftest  (selftest),
    .err_cnt   (err_cnt),
`endif
    .dout      (dout),
    .out_valid (out_valid),
    .leds      (leds),
    .clk_out   (clk_out)
  );

  typedef struct {
    logic [DSEL_W-1:0] sel;
    logic [7:0]        leds_exp;
    int                lat;
    logic [WIDTH-1:0]  sample;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [DSEL_W-1:0] sel);
    delay_sel = sel;
    load      = 1'b1;
    en        = 1'b0;
    tick();
    load      = 1'b0;
  endtask

  task automatic flush();
    en  = 1'b1;
    din = '0;
    repeat (MAX_DEPTH) tick();
    en  = 1'b0;
  endtask

  initial begin
    vecs[0] = '{sel: 9'd5,   leds_exp: 8'h05, lat: 5,   sample: 8'hA5};
    vecs[1] = '{sel: 9'd0,   leds_exp: 8'h01, lat: 1,   sample: 8'h5A};
    vecs[2] = '{sel: 9'd300, leds_exp: 8'h00, lat: 256, sample: 8'hC3};
    vecs[3] = '{sel: 9'd256, leds_exp: 8'h00, lat: 256, sample: 8'h81};
    vecs[4] = '{sel: 9'd1,   leds_exp: 8'h01, lat: 1,   sample: 8'h7E};
    vecs[5] = '{sel: 9'd255, leds_exp: 8'hFF, lat: 255, sample: 8'h3C};

    rst_n     = 1'b0;
    en        = 1'b0;
    din       = '0;
    delay_sel = '0;
    load      = 1'b0;
`ifdef NREG_SELFTEST_EN
    selftest  = 1'b0;
`endif

    // Reset state, then fill the full 256-stage default line with ones.
    repeat (2) tick();
    check("reset_dout", 32'(dout), 32'h0);
    check("reset_valid", 32'(out_valid), 32'h0);
    check("reset_leds", 32'(leds), 32'h00);
    rst_n = 1'b1;
    en    = 1'b1;
    din   = 8'h01;
    for (int e = 1; e <= 256; e++) begin
      tick();
      if (e == 255) begin
        check("fill256_valid_early", 32'(out_valid), 32'h0);
        check("fill256_dout_early", 32'(dout), 32'h0);
      end
      if (e == 256) begin
        check("fill256_valid", 32'(out_valid), 32'h1);
        check("fill256_dout", 32'(dout), 32'h1);
      end
    end
    en = 1'b0;

    // Table: single sample through each tap setting.
    for (int i = 0; i < 6; i++) begin
      flush();
      do_load(vecs[i].sel);
      check($sformatf("vec%0d_leds", i), 32'(leds), 32'(vecs[i].leds_exp));
      check($sformatf("vec%0d_valid_after_load", i), 32'(out_valid), 32'h0);
      en  = 1'b1;
      din = vecs[i].sample;
      tick();
      din = '0;
      for (int e = 1; e <= vecs[i].lat + 1; e++) begin
        if (e > 1) tick();
        if (e == vecs[i].lat - 1) begin
          check($sformatf("vec%0d_valid_pre", i), 32'(out_valid), 32'h0);
          check($sformatf("vec%0d_dout_pre", i), 32'(dout), 32'h0);
        end
        if (e == vecs[i].lat) begin
          check($sformatf("vec%0d_dout_hit", i), 32'(dout), 32'(vecs[i].sample));
          check($sformatf("vec%0d_valid_hit", i), 32'(out_valid), 32'h1);
        end
        if (e == vecs[i].lat + 1) begin
          check($sformatf("vec%0d_dout_post", i), 32'(dout), 32'h0);
        end
      end
      en = 1'b0;
    end

    // en gaps: d_act=4 with pattern en=1,0,0,1,1,1.
    flush();
    do_load(9'd4);
    en  = 1'b1;
    din = 8'h3C;
    tick();
    din = '0;
    en  = 1'b0;
    tick();
    check("gap_hold1_valid", 32'(out_valid), 32'h0);
    tick();
    check("gap_hold2_valid", 32'(out_valid), 32'h0);
    en = 1'b1;
    tick();
    check("gap_e4_valid", 32'(out_valid), 32'h0);
    tick();
    check("gap_e5_valid", 32'(out_valid), 32'h0);
    check("gap_e5_dout", 32'(dout), 32'h0);
    tick();
    check("gap_e6_dout", 32'(dout), 32'h3C);
    check("gap_e6_valid", 32'(out_valid), 32'h1);

    // Load 8, five enabled edges, then load 3 together with en.
    do_load(9'd8);
    en  = 1'b1;
    din = '0;
    repeat (5) tick();
    check("refill_valid_mid", 32'(out_valid), 32'h0);
    delay_sel = 9'd3;
    load      = 1'b1;
    tick();
    load = 1'b0;
    check("refill_leds", 32'(leds), 32'h03);
    check("refill_valid_load", 32'(out_valid), 32'h0);
    tick();
    tick();
    check("refill_valid_e2", 32'(out_valid), 32'h0);
    tick();
    check("refill_valid_e3", 32'(out_valid), 32'h1);

    // Asynchronous reset in the middle of a clock period.
    din = 8'h77;
    repeat (3) tick();
    check("midrst_dout_before", 32'(dout), 32'h77);
    check("midrst_valid_before", 32'(out_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_dout", 32'(dout), 32'h0);
    check("midrst_valid", 32'(out_valid), 32'h0);
    check("midrst_leds", 32'(leds), 32'h00);
    #1;
    rst_n = 1'b1;
    din   = '0;
    tick();
    check("postrst_valid", 32'(out_valid), 32'h0);
    check("postrst_dout", 32'(dout), 32'h0);
    en = 1'b0;

`ifdef NREG_SELFTEST_EN
    // Self-test: clean run, one corrupted sample, then clear by load.
    rst_n = 1'b0;
    tick();
    rst_n    = 1'b1;
    selftest = 1'b1;
    do_load(9'd10);
    en = 1'b1;
    repeat (1000) tick();
    check("st_err_clean", 32'(err_cnt), 32'h0);
    check("st_valid", 32'(out_valid), 32'h1);
    begin
      logic [31:0] pat_now;
      pat_now  = 32'd1000;
      din      = ~pat_now[WIDTH-1:0];
    end
    selftest = 1'b0;
    tick();
    selftest = 1'b1;
    din      = '0;
    repeat (20) tick();
    check("st_err_one", 32'(err_cnt), 32'h1);
    do_load(9'd10);
    check("st_err_cleared", 32'(err_cnt), 32'h0);
    selftest = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/nreg_delay_line.md
Name: nreg_delay_line

Overview:
- Parametrised successor to the fixed single-bit N-register chain.
- WIDTH-bit delay line, up to MAX_DEPTH stages, with runtime-selectable tap, clock enable, asynchronous active-low reset and a fill-based output-valid flag.
- Sits between an external stimulus/capture pin group and board LEDs, for timing and clock-quality experiments on the external clock.

Parameters:
- WIDTH, 1, data bits per stage.
- MAX_DEPTH, 256, number of physical stages; legal range 1..256.
- DSEL_W, $clog2(MAX_DEPTH)+1 (9 for 256), width of delay_sel; derived localparam, not overridden.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  shift enable; stages advance only when high.
- din  input  WIDTH  data into stage 0.
- delay_sel  input  DSEL_W  requested delay in enabled cycles.
- load  input  1  one-cycle strobe; captures delay_sel.
- dout  output  WIDTH  tapped stage output.
- out_valid  output  1  dout holds data that entered after the last load/reset.
- leds  output  8  active delay d_act[7:0].
- clk_out  output  1  direct pass-through of clk for scope monitoring.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values:
  - all stages 0; dout 0.
  - d_act = MAX_DEPTH.
  - fill counter 0; out_valid 0.
  - leds = MAX_DEPTH[7:0].
  - Error counter 0 (when the optional feature is compiled in).
- Shift: on a clk edge with en=1, stage[0] <= din and stage[k] <= stage[k-1]. With en=0, all stages hold.
- Tap: dout = stage[d_act-1] through a combinational mux. A sample presented with en=1 appears on dout after exactly d_act enabled edges. d_act=1 gives one-cycle latency.
- Delay capture:
  - On load=1, d_act <= clamp(delay_sel).
  - delay_sel 0 maps to 1; values above MAX_DEPTH map to MAX_DEPTH.
  - New d_act drives the tap mux from the next cycle.
- Fill counter (DSEL_W bits):
  - load=1 → counter cleared to 0 and out_valid cleared, regardless of en.
  - Otherwise, en=1 and counter < d_act → increment.
  - Saturates at d_act; never wraps.
  - out_valid registered, =1 iff counter == d_act.
- Simultaneous load and en: stages still shift that edge. The fill counter is cleared, not incremented, so out_valid rises d_act enabled edges after the load edge.
- load during fill: restarts the fill from 0 with the new d_act. Stage contents are not cleared.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). First enabled edge after deassertion behaves as edge 1 of a fresh fill.
- Stage contents never gate dout: dout shows stale or zero data while out_valid=0.

Optional Feature:
- Macro: NREG_SELFTEST_EN.
- With the macro:
  - Extra input selftest (1 bit) and output err_cnt (16 bits, reset 0).
  - When selftest=1, stage 0 takes a free-running WIDTH-bit counter pat (reset 0, +1 on each en edge) instead of din.
  - On each en edge with out_valid=1 and selftest=1, the block compares dout against (pat - d_act) mod 2^WIDTH. Each mismatch increments err_cnt, saturating at 16'hFFFF.
  - load clears err_cnt.
- Without the macro: the ports, counter and comparator are absent; behaviour is identical to the selftest=0 case.

Decomposition:
- Shared package nreg_pkg:
  - NREG_MAX_DEPTH_LIMIT = 256.
  - ERRCNT_W = 16.
  - clamp_delay function (delay_sel → d_act).
- One natural sub-module: nreg_tap_mux (stage array → dout selected by d_act), reusable by later multi-channel variants.
- The stage array stays in the top module as a generate loop.

Test Plan:
- Reset then idle: rst_n low → dout=0, out_valid=0, leds=8'h00 (MAX_DEPTH=256). With en=1, din=1 (WIDTH=1) → out_valid rises and dout=1 after exactly 256 enabled edges.
- Load delay_sel=5, en=1, din=0xA5 for one cycle then 0 (WIDTH=8) → dout=0xA5 on the 5th edge after the sample, for exactly one cycle. out_valid high from the 5th edge after load; leds=8'h05.
- Clamping: delay_sel=0 → leds=1, latency 1. delay_sel=300 → leds=8'h00 (d_act=256), latency 256.
- en gaps: d_act=4, pattern en=1,0,0,1,1,1 → sample emerges after 4 enabled edges (6 clocks). out_valid stays 0 during the holds.
- Load during fill plus mid-stream reset:
  - load 8, then load 3 after 5 en cycles → out_valid 3 edges later.
  - rst_n pulsed low mid-stream → out_valid and dout drop to 0 immediately, without waiting for a clock edge.
- NREG_SELFTEST_EN, selftest=1:
  - d_act=10 for 1000 en cycles → err_cnt=0.
  - Force a single stage bit flip → err_cnt=1.
  - load → err_cnt=0.
